// File: rtl/pio_irq_dbnc.sv
// -----------------------------------------------------------------------------
// pio_irq_dbnc
//   Avalon-MM parallel I/O slave with per-bit input synchronisation and
//   debounce, sticky edge capture on a selectable edge, a masked level
//   interrupt and atomic set/clear of output bits.
//
// Ports
//   clk_clk         system clock, rising edge
//   reset_reset_n   asynchronous active-low reset
//   avs_address     word address (8 registers)
//   avs_read        read strobe, readdata valid one cycle later
//   avs_write       write strobe
//   avs_writedata   write data (bits above a register's width ignored)
//   avs_readdata    registered read data, holds until the next read
//   irq             |(edge_cap & irq_mask), level, active-high
//   pio_out_export  output pins, driven straight from the DATA_OUT register
//   pio_in_export   asynchronous input pins
// -----------------------------------------------------------------------------
module pio_irq_dbnc #(
    parameter int unsigned          WIDTH_OUT       = 8,
    parameter int unsigned          WIDTH_IN        = 8,
    parameter logic [WIDTH_OUT-1:0] OUT_RESET       = '0,
    parameter int unsigned          SYNC_STAGES     = 2,
    parameter int unsigned          DEBOUNCE_CYCLES = 1,
    parameter int unsigned          EDGE_MODE       = 0
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    input  logic [2:0]           avs_address,
    input  logic                 avs_read,
    input  logic                 avs_write,
    input  logic [31:0]          avs_writedata,
    output logic [31:0]          avs_readdata,
    output logic                 irq,
    output logic [WIDTH_OUT-1:0] pio_out_export,
    input  logic [WIDTH_IN-1:0]  pio_in_export
);

    localparam int unsigned    CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] ADDR_DATA_IN  = 3'd0;
    localparam logic [2:0] ADDR_DATA_OUT = 3'd1;
    localparam logic [2:0] ADDR_OUT_SET  = 3'd2;
    localparam logic [2:0] ADDR_OUT_CLR  = 3'd3;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd4;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd5;
    localparam logic [2:0] ADDR_CONFIG   = 3'd6;

    localparam logic [31:0] CONFIG_WORD = {16'(DEBOUNCE_CYCLES), 2'b00,
                                           2'(EDGE_MODE), 6'(WIDTH_OUT),
                                           6'(WIDTH_IN)};

    logic [WIDTH_IN-1:0]  sync_q [SYNC_STAGES];
    logic [CNT_W-1:0]     cnt_q  [WIDTH_IN];
    logic [CNT_W-1:0]     cnt_d  [WIDTH_IN];
    logic [WIDTH_IN-1:0]  stable_q, stable_d;
    logic [WIDTH_IN-1:0]  edge_cap_q, edge_cap_d, edge_hit, w1c_mask;
    logic [WIDTH_IN-1:0]  irq_mask_q;
    logic [WIDTH_OUT-1:0] out_d;
    logic [WIDTH_IN-1:0]  sync_now;
    logic [31:0]          rd_mux;

    // Every write-data bit is folded here so partially used words stay lint-quiet.
    logic unused_wdata;
    assign unused_wdata = ^avs_writedata;

    assign sync_now = sync_q[SYNC_STAGES-1];

    // NOTE: the synchroniser and counter arrays are reset like ordinary flops,
    // so a reset in the middle of a debounce window discards the partial count.
    // NOTE: sequential state is assigned with <= only; blocking assignments are
    // kept to the combinational next-state blocks.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= pio_in_export;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    // Debounce: a bit is accepted once sync has differed from stable for
    // DEBOUNCE_CYCLES consecutive edges; any return to stable restarts it.
    // NOTE: every variable gets a default at the top of the block so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < WIDTH_IN; i++) begin
            cnt_d[i] = '0;
            if (sync_now[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) stable_d[i] = sync_now[i];
                else                      cnt_d[i]    = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Transition qualifier chosen at elaboration time.
    always_comb begin
        case (EDGE_MODE)
            0:       edge_hit = stable_d & ~stable_q;
            1:       edge_hit = ~stable_d & stable_q;
            default: edge_hit = stable_d ^ stable_q;
        endcase
    end

    // W1C is applied first and the new edge ORed after, so a coincident
    // capture always survives the clear.
    always_comb begin
        w1c_mask = '0;
        if (avs_write && avs_address == ADDR_EDGE_CAP)
            w1c_mask = avs_writedata[WIDTH_IN-1:0];
        edge_cap_d = (edge_cap_q & ~w1c_mask) | edge_hit;
    end

    always_comb begin
        out_d = pio_out_export;
        if (avs_write) begin
            case (avs_address)
                ADDR_DATA_OUT: out_d = avs_writedata[WIDTH_OUT-1:0];
                ADDR_OUT_SET:  out_d = pio_out_export | avs_writedata[WIDTH_OUT-1:0];
                ADDR_OUT_CLR:  out_d = pio_out_export & ~avs_writedata[WIDTH_OUT-1:0];
                default:       out_d = pio_out_export;
            endcase
        end
    end

    // Read mux sees only pre-edge register values, so a read that coincides
    // with a write or a capture returns the old contents.
    always_comb begin
        rd_mux = '0;
        case (avs_address)
            ADDR_DATA_IN:  rd_mux[WIDTH_IN-1:0]  = stable_q;
            ADDR_DATA_OUT: rd_mux[WIDTH_OUT-1:0] = pio_out_export;
            ADDR_IRQ_MASK: rd_mux[WIDTH_IN-1:0]  = irq_mask_q;
            ADDR_EDGE_CAP: rd_mux[WIDTH_IN-1:0]  = edge_cap_q;
            ADDR_CONFIG:   rd_mux                = CONFIG_WORD;
            default:       rd_mux                = '0;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < WIDTH_IN; i++) cnt_q[i] <= '0;
            stable_q       <= '0;
            edge_cap_q     <= '0;
            irq_mask_q     <= '0;
            pio_out_export <= OUT_RESET;
            avs_readdata   <= '0;
        end else begin
            for (int i = 0; i < WIDTH_IN; i++) cnt_q[i] <= cnt_d[i];
            stable_q       <= stable_d;
            edge_cap_q     <= edge_cap_d;
            pio_out_export <= out_d;
            if (avs_write && avs_address == ADDR_IRQ_MASK)
                irq_mask_q <= avs_writedata[WIDTH_IN-1:0];
            if (avs_read)
                avs_readdata <= rd_mux;
        end
    end

    // Decoded straight from flops so a capture or an unmasking write shows
    // up in the cycle right after its edge.
    assign irq = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_pio_irq_dbnc.sv
// -----------------------------------------------------------------------------
// tb_pio_irq_dbnc
//   Two instances (rising-edge and any-edge capture) share one bus and one set
//   of input pins. A window-based reference model predicts outputs every
//   cycle; directed steps add literal expectations.
// -----------------------------------------------------------------------------
module tb_pio_irq_dbnc;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int MODE [2] = '{0, 2};

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [2:0]  avs_address = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [7:0]  pins = '0;

    logic [31:0] rd0, rd2;
    logic        irq0, irq2;
    logic [7:0]  out0, out2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pio_irq_dbnc #(.WIDTH_OUT(8), .WIDTH_IN(8), .OUT_RESET(8'hA5),
                   .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .EDGE_MODE(0)) u_dut0 (
        .clk_clk(clk), .reset_reset_n(rst_n), .avs_address(avs_address),
        .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
        .avs_readdata(rd0), .irq(irq0), .pio_out_export(out0), .pio_in_export(pins));

    pio_irq_dbnc #(.WIDTH_OUT(8), .WIDTH_IN(8), .OUT_RESET(8'hA5),
                   .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .EDGE_MODE(2)) u_dut2 (
        .clk_clk(clk), .reset_reset_n(rst_n), .avs_address(avs_address),
        .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
        .avs_readdata(rd2), .irq(irq2), .pio_out_export(out2), .pio_in_export(pins));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  hist [$];   // hist[j] = pin sample taken j+1 edges ago
    logic [7:0]  m_out, m_mask, m_stable;
    logic [7:0]  m_cap [2];
    logic [31:0] m_rd  [2];
    logic [7:0]  n_stab, rise, fall, w1c, hit, smp;
    logic        all_diff;

    function automatic logic [31:0] reg_val(input int m, input logic [2:0] a);
        case (a)
            3'd0:    return {24'h0, m_stable};
            3'd1:    return {24'h0, m_out};
            3'd4:    return {24'h0, m_mask};
            3'd5:    return {24'h0, m_cap[m]};
            3'd6:    return DEB * 65536 + MODE[m] * 4096 + 8 * 64 + 8;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist = {};
            for (int j = 0; j < SYNC + DEB - 1; j++) hist.push_back(8'h00);
            m_out = 8'hA5; m_mask = 8'h00; m_stable = 8'h00;
            for (int m = 0; m < 2; m++) begin m_cap[m] = 8'h00; m_rd[m] = 32'h0; end
        end else begin
            // A bit flips once the last DEB synchronised samples all disagree with it.
            n_stab = m_stable;
            for (int i = 0; i < 8; i++) begin
                all_diff = 1'b1;
                for (int t = 0; t < DEB; t++) begin
                    smp = hist[SYNC - 1 + t];
                    if (smp[i] == m_stable[i]) all_diff = 1'b0;
                end
                if (all_diff) n_stab[i] = ~m_stable[i];
            end
            rise = n_stab & ~m_stable;
            fall = ~n_stab & m_stable;
            w1c  = (avs_write && avs_address == 3'd5) ? avs_writedata[7:0] : 8'h00;
            for (int m = 0; m < 2; m++) begin
                hit = (MODE[m] == 0) ? rise : (MODE[m] == 1) ? fall : (rise | fall);
                if (avs_read) m_rd[m] = reg_val(m, avs_address);
                m_cap[m] = (m_cap[m] & ~w1c) | hit;
            end
            if (avs_write) begin
                case (avs_address)
                    3'd1: m_out  = avs_writedata[7:0];
                    3'd2: m_out  = m_out | avs_writedata[7:0];
                    3'd3: m_out  = m_out & ~avs_writedata[7:0];
                    3'd4: m_mask = avs_writedata[7:0];
                    default: ;
                endcase
            end
            m_stable = n_stab;
            hist.push_front(pins);
            void'(hist.pop_back());
        end
    end

    // Every-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        check("out0", {24'h0, out0}, {24'h0, m_out});
        check("out2", {24'h0, out2}, {24'h0, m_out});
        check("irq0", {31'h0, irq0}, {31'h0, |(m_cap[0] & m_mask)});
        check("irq2", {31'h0, irq2}, {31'h0, |(m_cap[1] & m_mask)});
        check("rd0", rd0, m_rd[0]);
        check("rd2", rd2, m_rd[1]);
    end

    // ---------------- directed stimulus ----------------
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, input logic [31:0] e0,
                            input logic [31:0] e2, input string name);
        avs_address = a; avs_read = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        check({name, ".d0"}, rd0, e0);
        check({name, ".d2"}, rd2, e2);
    endtask

    task automatic read_all_after_reset();
        logic [31:0] e0 [8];
        logic [31:0] e2 [8];
        e0 = '{32'h0, 32'hA5, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0004_0208, 32'h0};
        e2 = '{32'h0, 32'hA5, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0004_2208, 32'h0};
        for (int a = 0; a < 8; a++) bus_read(3'(a), e0[a], e2[a], $sformatf("rst_rd%0d", a));
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_out", {24'h0, out0}, 32'hA5);
        check("rst_irq", {31'h0, irq0}, 32'h0);
        read_all_after_reset();

        // Output register operations on consecutive cycles.
        bus_write(3'd1, 32'h0000_000F); check("wr_out", {24'h0, out0}, 32'h0F);
        bus_write(3'd2, 32'h0000_0030); check("set_out", {24'h0, out0}, 32'h3F);
        bus_write(3'd3, 32'h0000_0003); check("clr_out", {24'h0, out0}, 32'h3C);
        bus_read(3'd2, 32'h0, 32'h0, "rd_set");
        bus_write(3'd1, 32'hFFFF_FF5A);
        bus_read(3'd1, 32'h5A, 32'h5A, "rd_out_hi");
        bus_write(3'd4, 32'hFFFF_FF01);
        bus_read(3'd4, 32'h01, 32'h01, "rd_mask");

        // Short glitch: three sampled highs are not enough.
        pins = 8'h01;
        repeat (3) @(negedge clk);
        pins = 8'h00;
        repeat (10) @(negedge clk);
        bus_read(3'd0, 32'h0, 32'h0, "glitch_in");
        bus_read(3'd5, 32'h0, 32'h0, "glitch_cap");

        // Held high: accepted on the sixth edge; a coincident capture read sees the old value.
        pins = 8'h01;
        repeat (5) @(negedge clk);
        check("irq_pre", {31'h0, irq0}, 32'h0);
        bus_read(3'd5, 32'h0, 32'h0, "cap_coincide");
        check("irq_rise0", {31'h0, irq0}, 32'h1);
        check("irq_rise2", {31'h0, irq2}, 32'h1);
        bus_read(3'd0, 32'h01, 32'h01, "in_high");
        bus_read(3'd5, 32'h01, 32'h01, "cap_rise");

        // Falling edge: no new capture in rising mode.
        pins = 8'h00;
        repeat (10) @(negedge clk);
        bus_read(3'd0, 32'h0, 32'h0, "in_low");
        bus_read(3'd5, 32'h01, 32'h01, "cap_fall");
        bus_write(3'd5, 32'h0000_0001);
        check("irq_w1c0", {31'h0, irq0}, 32'h0);
        check("irq_w1c2", {31'h0, irq2}, 32'h0);
        bus_read(3'd5, 32'h0, 32'h0, "cap_clr");

        // W1C on the very edge that captures bit 2: the capture survives.
        pins = 8'h04;
        repeat (5) @(negedge clk);
        bus_write(3'd5, 32'h0000_0004);
        bus_read(3'd5, 32'h04, 32'h04, "collision");

        // Late mask: falling edge on bit 3 captured only in any-edge mode.
        bus_write(3'd4, 32'h0);
        pins = 8'h0C;
        repeat (10) @(negedge clk);
        bus_write(3'd5, 32'h0000_00FF);
        bus_read(3'd5, 32'h0, 32'h0, "cap_clr_all");
        pins = 8'h04;
        repeat (10) @(negedge clk);
        bus_read(3'd5, 32'h0, 32'h08, "cap_any");
        check("irq_masked", {31'h0, irq2}, 32'h0);
        bus_write(3'd4, 32'h0000_0008);
        check("irq_late0", {31'h0, irq0}, 32'h0);
        check("irq_late2", {31'h0, irq2}, 32'h1);

        // Asynchronous reset in the middle of a debounce window.
        bus_write(3'd1, 32'h0000_0011);
        pins = 8'h06;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out0", {24'h0, out0}, 32'hA5);
        check("arst_out2", {24'h0, out2}, 32'hA5);
        check("arst_irq2", {31'h0, irq2}, 32'h0);
        pins = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        read_all_after_reset();

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
